round_ctrl: RTL
===============

ROUND_CTRL -- requirements
Module: round_ctrl

Interface
REQ-001 SHALL have parameter ROUNDS, default 4, number of full rounds (legal 1..15).
REQ-002 SHALL have port clk, input, 1, sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, reset; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port req, input, 1, start request (4-phase handshake).
REQ-005 SHALL have port ack, output, 1, result valid / completion acknowledge.
REQ-006 SHALL have port busy, output, 1, high while a computation is in progress.
REQ-007 SHALL have port din, input, 16, plaintext block.
REQ-008 SHALL have port key, input, 16, cipher key.
REQ-009 SHALL have port dout, output, 16, result block.
REQ-010 SHALL have port sbox_x, output, 4, nibble presented to the shared external 4-bit S-box.
REQ-011 SHALL have port sbox_r, input, 4, combinational S-box result for sbox_x.

Function
REQ-012 SHALL implement states IDLE, ADD, SUB, PERM, DONE; reset state IDLE.
REQ-013 In IDLE, req=1 at a rising edge SHALL latch din into a 16-bit state register, latch key, clear the round counter rnd to 0, and enter ADD.
REQ-014 ADD SHALL set state = state ^ (key ^ {12'b0, rnd}) in one cycle; it SHALL then go to SUB if rnd < ROUNDS, else to DONE.
REQ-015 SUB SHALL last exactly 4 cycles, nibble index n = 0,1,2,3; in cycle n, sbox_x = state[4n+3:4n] and state[4n+3:4n] <= sbox_r.
REQ-016 After n=3, the FSM SHALL go to PERM; PERM SHALL rotate state left by 3 bits in one cycle, increment rnd, and return to ADD.
REQ-017 Latency SHALL be 6*ROUNDS+1 cycles from the edge sampling req=1 in IDLE to the edge entering DONE (25 for ROUNDS=4).
REQ-018 On entering DONE, dout SHALL be loaded with state; ack SHALL be 1 throughout DONE.
REQ-019 DONE SHALL exit to IDLE on the first edge where req=0; ack SHALL fall on that edge.
REQ-020 If req is already 0 on entering DONE, ack SHALL be high for exactly one cycle.
REQ-021 req changes while in ADD/SUB/PERM SHALL be ignored; din/key changes after the latching edge SHALL have no effect.
REQ-022 busy SHALL be 1 exactly in ADD, SUB, PERM; 0 in IDLE and DONE.
REQ-023 sbox_x SHALL be 4'h0 in every state other than SUB.
REQ-024 dout SHALL hold its value from DONE until the next entry to DONE; it SHALL not change during a later computation.
REQ-025 A new operation SHALL start only from IDLE; req held high across DONE->IDLE cannot occur because DONE exits only on req=0.

Reset
REQ-026 rst=1 SHALL immediately (without a clock edge) force state IDLE, ack=0, busy=0, dout=16'h0000, internal state/key/rnd/n = 0, sbox_x=4'h0.
REQ-027 Reset asserted mid-operation SHALL abandon the computation; after release, the block SHALL wait in IDLE for a fresh req.

Verification
REQ-028 ROUNDS=1, identity S-box (sbox_r=sbox_x), din=16'h0000, key=16'h0000, req pulse -> ack after 7 cycles, dout=16'h0001.
REQ-029 ROUNDS=1, identity S-box, din=16'h8000, key=16'h0000 -> dout=16'h0005 (ADD 8000, SUB 8000, rotl3 0004, final ^0001).
REQ-030 ROUNDS=1, complement S-box (sbox_r=~sbox_x), din=16'h0000, key=16'h0000 -> dout=16'hFFFE; sbox_x observed 0,0,0,0 during SUB cycles.
REQ-031 ROUNDS=4, req held high -> busy high 25 cycles, ack rises at cycle 25 and stays high until req dropped, falls on next edge; req dropped at cycle 3 -> ack single-cycle pulse.
REQ-032 ROUNDS=4, rst asserted asynchronously at cycle 10 -> ack=0, busy=0, dout=16'h0000 immediately; new req after release -> full 25-cycle run with correct result.

Source files
------------

// File: rtl/round_ctrl.sv
// round_ctrl: iterative 16-bit round engine. It runs ROUNDS rounds of
// key-add, a nibble-serial substitution through a shared external 4-bit
// S-box, and a 3-bit left rotation. A final key-add follows the last round.
// The start/finish handshake is a 4-phase req/ack pair.
module round_ctrl #(
    parameter int ROUNDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    output logic        ack,
    output logic        busy,
    input  logic [15:0] din,
    input  logic [15:0] key,
    output logic [15:0] dout,
    output logic [3:0]  sbox_x,
    input  logic [3:0]  sbox_r
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADD  = 3'd1,
        SUB  = 3'd2,
        PERM = 3'd3,
        DONE = 3'd4
    } fsm_t;

    // Round index at which the final key-add ends the computation
    localparam logic [3:0] LAST_RND = 4'(ROUNDS);

    fsm_t        fsm_reg;
    logic [15:0] state_reg;
    logic [15:0] key_reg;
    logic [3:0]  rnd_reg;
    logic [1:0]  nib_reg;

    logic [15:0] add_next;
    logic [15:0] sub_next;
    logic [15:0] perm_next;

    // Round key is the latched key with the round number folded into the low nibble
    assign add_next  = state_reg ^ (key_reg ^ {12'b0, rnd_reg});
    assign perm_next = {state_reg[12:0], state_reg[15:13]};

    // Only the nibble currently selected by nib_reg takes the S-box result
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sub
            assign sub_next[4*gi +: 4] = (nib_reg == 2'(gi)) ? sbox_r : state_reg[4*gi +: 4];
        end
    endgenerate

    // Present the active nibble to the S-box during SUB; hold it at zero otherwise
    always_comb begin
        sbox_x = 4'h0;
        if (fsm_reg == SUB) begin
            sbox_x = state_reg[{nib_reg, 2'b00} +: 4];
        end
    end

    // Control FSM with datapath registers and registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_reg   <= IDLE;
            state_reg <= 16'h0000;
            key_reg   <= 16'h0000;
            rnd_reg   <= 4'h0;
            nib_reg   <= 2'd0;
            dout      <= 16'h0000;
            ack       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (fsm_reg)
                IDLE: begin
                    if (req) begin
                        state_reg <= din;
                        key_reg   <= key;
                        rnd_reg   <= 4'h0;
                        nib_reg   <= 2'd0;
                        busy      <= 1'b1;
                        fsm_reg   <= ADD;
                    end
                end
                ADD: begin
                    state_reg <= add_next;
                    nib_reg   <= 2'd0;
                    if (rnd_reg < LAST_RND) begin
                        fsm_reg <= SUB;
                    end else begin
                        // Final key-add: publish the result as DONE is entered
                        dout    <= add_next;
                        busy    <= 1'b0;
                        ack     <= 1'b1;
                        fsm_reg <= DONE;
                    end
                end
                SUB: begin
                    state_reg <= sub_next;
                    nib_reg   <= nib_reg + 2'd1;
                    if (nib_reg == 2'd3) begin
                        fsm_reg <= PERM;
                    end
                end
                PERM: begin
                    state_reg <= perm_next;
                    rnd_reg   <= rnd_reg + 4'd1;
                    fsm_reg   <= ADD;
                end
                DONE: begin
                    // Leave only once the requester has withdrawn req
                    if (!req) begin
                        ack     <= 1'b0;
                        fsm_reg <= IDLE;
                    end
                end
                default: begin
                    fsm_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
